// File: rtl/plab5_mcore_sec_switch_ctrl_if.sv
// rtl/plab5_mcore_sec_switch_ctrl_if.sv - handshake bundle between core, switch requester and network
interface plab5_mcore_sec_switch_ctrl_if;
  logic switch_req_val;
  logic switch_req_rdy;
  logic switch_req_level;
  logic switch_done;
  logic proc_req_val;
  logic proc_req_rdy;
  logic net_req_val;
  logic net_req_rdy;
  logic resp_val;
  logic resp_rdy;

  modport master (
    output switch_req_val, switch_req_level, proc_req_val, net_req_rdy, resp_val, resp_rdy,
    input  switch_req_rdy, switch_done, proc_req_rdy, net_req_val
  );

  modport slave (
    input  switch_req_val, switch_req_level, proc_req_val, net_req_rdy, resp_val, resp_rdy,
    output switch_req_rdy, switch_done, proc_req_rdy, net_req_val
  );
endinterface

// File: rtl/plab5_mcore_sec_switch_ctrl.sv
// rtl/plab5_mcore_sec_switch_ctrl.sv - security-level switch sequencer with request gating and drain
module plab5_mcore_sec_switch_ctrl #(
  parameter int p_max_outstanding = 4,
  parameter bit p_reset_level     = 1'b0,
  localparam int cw               = $clog2(p_max_outstanding + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  plab5_mcore_sec_switch_ctrl_if.slave       bus,
  output logic                               proc_sec_level,
  output logic [cw-1:0]                      outstanding,
  output logic                               err
);

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [cw-1:0] LP_MAX = cw'(p_max_outstanding);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_level;
  logic          r_pending;
  logic [cw-1:0] r_count;
  logic          r_err;
  logic          w_open_ok;
  logic          w_req_fire;
  logic          w_resp_fire;
  logic          w_load_level;

  // A switch request on the wire already closes the gate, so no request slips in beside it.
  assign w_open_ok   = (r_state == ST_OPEN) & ~bus.switch_req_val & (r_count < LP_MAX);
  assign w_req_fire  = bus.proc_req_val & bus.net_req_rdy & w_open_ok;
  assign w_resp_fire = bus.resp_val & bus.resp_rdy;

  assign bus.net_req_val    = bus.proc_req_val & w_open_ok;
  assign bus.proc_req_rdy   = bus.net_req_rdy & w_open_ok;
  assign bus.switch_req_rdy = (r_state == ST_OPEN);
  assign bus.switch_done    = (r_state == ST_SETTLE);

  assign proc_sec_level = r_level;
  assign outstanding    = r_count;
  assign err            = r_err;

  always_comb begin
    w_state_next = r_state;
    w_load_level = 1'b0;
    case (r_state)
      ST_OPEN: begin
        if (bus.switch_req_val) begin
          w_state_next = (bus.switch_req_level != r_level) ? ST_DRAIN : ST_SETTLE;
        end
      end
      ST_DRAIN: begin
        if (r_count == '0) begin
          w_state_next = ST_SETTLE;
          w_load_level = 1'b1;
        end
      end
      ST_SETTLE: w_state_next = ST_OPEN;
      default:   w_state_next = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_OPEN;
      r_level   <= p_reset_level;
      r_pending <= p_reset_level;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_OPEN) && bus.switch_req_val) begin
        r_pending <= bus.switch_req_level;
      end
      if (w_load_level) begin
        r_level <= r_pending;
      end
    end
  end

  // Underflow leaves the count at zero and latches the error until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case ({w_req_fire, w_resp_fire})
        2'b10: r_count <= r_count + cw'(1);
        2'b01: begin
          if (r_count == '0) begin
            r_err <= 1'b1;
          end else begin
            r_count <= r_count - cw'(1);
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/plab5_mcore_sec_switch_ctrl.md
# plab5_mcore_sec_switch_ctrl

Controller that owns the `proc_sec_level` signal feeding the processor response access-control path, and sequences security-domain switches for one core. It passes processor memory requests through to the network, counts outstanding requests, and on a switch request blocks new requests, drains in-flight responses, then flips the level. No response tagged under the old level is ever delivered under the new one.

## Interface
Parameters:
- `p_max_outstanding`, default 4: maximum in-flight requests. The counter is `$clog2(p_max_outstanding+1)` bits wide (`cw`).
- `p_reset_level`, default 0: value of `proc_sec_level` after reset.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `switch_req_val`  in  1  request to set the domain.
- `switch_req_rdy`  out  1  switch request accepted when val&rdy.
- `switch_req_level`  in  1  requested level.
- `switch_done`  out  1  one-cycle pulse: new level in effect.
- `proc_req_val`  in  1  processor memory request valid.
- `proc_req_rdy`  out  1  gated ready to processor.
- `net_req_val`  out  1  gated valid to network.
- `net_req_rdy`  in  1  network ready.
- `resp_val`  in  1  monitored processor-side response valid.
- `resp_rdy`  in  1  monitored processor-side response ready.
- `proc_sec_level`  out  1  registered level to the response access-control path.
- `outstanding`  out  `cw`  current in-flight count.
- `err`  out  1  sticky underflow flag.

## Operation
- States: OPEN, DRAIN, SETTLE. Registers: state, `proc_sec_level`, `pending_level`, count, `err`.
- Gating:
  - `open_ok` = (state==OPEN) & !`switch_req_val` & (count < `p_max_outstanding`).
  - `net_req_val` = `proc_req_val` & `open_ok`.
  - `proc_req_rdy` = `net_req_rdy` & `open_ok`.
  - Otherwise both outputs are 0.
  - A pending switch request therefore blocks requests in the same cycle.
- `req_fire` = `net_req_val` & `net_req_rdy`. `resp_fire` = `resp_val` & `resp_rdy`.
- Counter:
  - +1 on `req_fire` only.
  - -1 on `resp_fire` only.
  - Unchanged on both or neither.
  - `resp_fire` with count==0: count stays 0, `err` <= 1 (sticky until reset).
  - `req_fire` cannot occur at count==`p_max_outstanding`, so the counter never wraps.
- `switch_req_rdy` = (state==OPEN).
- OPEN, on accept:
  - `pending_level` <= `switch_req_level`.
  - If `switch_req_level` != `proc_sec_level`, next state is DRAIN; otherwise next state is SETTLE (no-op switch).
- DRAIN:
  - Requests are blocked.
  - If the registered count==0: `proc_sec_level` <= `pending_level` and next state is SETTLE.
  - Otherwise stay in DRAIN.
- SETTLE:
  - `switch_done`=1 (Moore output); requests are blocked.
  - Next state is OPEN unconditionally.
- Responses are never blocked by this block; it only observes them.

## Timing
- Reset (asynchronous, active-low; applies whenever `reset`=0, including mid-DRAIN):
  - state=OPEN, count=0, `err`=0, `pending_level`=`p_reset_level`, `proc_sec_level`=`p_reset_level`.
  - Outputs during and after reset: `switch_done`=0, `switch_req_rdy`=1.
  - `net_req_val` and `proc_req_rdy` are 0 while `switch_req_val`=1, otherwise per the gating rules.
  - An interrupted switch is lost; the requester must reissue it.
- Level-changing switch accepted at cycle T with count 0:
  - T+1: DRAIN.
  - T+2: SETTLE, new `proc_sec_level` visible, `switch_done`=1.
  - T+3: OPEN, requests pass.
- Same-level switch accepted at T: T+1 SETTLE (`switch_done`=1), T+2 OPEN.
- Count N>0 at entry to DRAIN: SETTLE occurs one cycle after the cycle in which the registered count first reads 0.
- `proc_sec_level` changes only on the DRAIN->SETTLE edge or on reset, never while count>0.
- `outstanding` equals the registered count (no bypass).

## Test plan
- Reset with `p_reset_level`=1 -> `proc_sec_level`=1, `outstanding`=0, `err`=0, `switch_req_rdy`=1.
- Issue 4 requests with `net_req_rdy`=1 and no responses -> `outstanding`=4. 5th `proc_req_val` -> `proc_req_rdy`=0, `net_req_val`=0. One `resp_fire` -> the next request is accepted.
- Level 0, 2 outstanding, switch to 1 -> DRAIN, requests blocked. After 2 responses the level becomes 1 with `switch_done` pulsed exactly once, then OPEN. The level stays 0 while `outstanding`>0.
- Switch to the current level with 0 outstanding -> `switch_done` at T+1, OPEN at T+2, `proc_sec_level` unchanged.
- Same cycle `switch_req_val`=1 and `proc_req_val`=1 in OPEN -> no `req_fire`, switch accepted.
- `resp_fire` at count 0 -> `err`=1 and count stays 0. Assert `reset`=0 mid-DRAIN -> immediate return to reset values, `err` cleared.
